// File: rtl/toggle_handshake_rx_pkg.sv
// Shared types and defaults for the toggle-handshake receiver.
// State encoding plus default parameter values.
package toggle_handshake_rx_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } state_e;

  localparam int DEF_WIDTH       = 8;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_CNT_WIDTH   = 8;

endpackage

// File: rtl/toggle_handshake_rx_if.sv
// Toggle request link plus downstream valid/ready bundle.
// master: sender/consumer side; slave: the receiver block.
interface toggle_handshake_rx_if
  import toggle_handshake_rx_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             REQ;
  logic [WIDTH-1:0] DATA;
  logic             ACK;
  logic             OUT_VALID;
  logic [WIDTH-1:0] OUT_DATA;
  logic             OUT_READY;

  modport master (
    output REQ,
    output DATA,
    output OUT_READY,
    input  ACK,
    input  OUT_VALID,
    input  OUT_DATA
  );

  modport slave (
    input  REQ,
    input  DATA,
    input  OUT_READY,
    output ACK,
    output OUT_VALID,
    output OUT_DATA
  );
endinterface

// File: rtl/toggle_sync.sv
// Multi-flop level synchroniser with async active-low reset.
// Ports: CLK, RST (active-low), D (async level in), Q (synced out).
module toggle_sync
  import toggle_handshake_rx_pkg::*;
#(
  parameter int STAGES = DEF_SYNC_STAGES
) (
  input  logic CLK,
  input  logic RST,
  input  logic D,
  output logic Q
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sr <= '0;
    end else begin
      sr <= {sr[STAGES-2:0], D};
    end
  end

  assign Q = sr[STAGES-1];

endmodule

// File: rtl/toggle_handshake_rx.sv
// Receive side of a two-phase toggle link: sync REQ, capture DATA,
// hand off via valid/ready, return toggle ACK. Ports: CLK, RST, bus, COUNT, ERR.
module toggle_handshake_rx
  import toggle_handshake_rx_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH
) (
  input  logic                 CLK,
  input  logic                 RST,
  toggle_handshake_rx_if.slave bus,
  output logic [CNT_WIDTH-1:0] COUNT,
  output logic                 ERR
);

  state_e               state, state_n;
  logic                 req_s;
  logic                 req_seen, req_seen_n;
  logic                 valid, valid_n;
  logic [WIDTH-1:0]     data, data_n;
  logic                 ack, ack_n;
  logic [CNT_WIDTH-1:0] cnt, cnt_n;
  logic                 err, err_n;
  logic                 toggle_det;

  toggle_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .CLK (CLK),
    .RST (RST),
    .D   (bus.REQ),
    .Q   (req_s)
  );

  assign toggle_det = req_s ^ req_seen;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      req_seen <= 1'b0;
      valid    <= 1'b0;
      data     <= '0;
      ack      <= 1'b0;
      cnt      <= '0;
      err      <= 1'b0;
    end else begin
      state    <= state_n;
      req_seen <= req_seen_n;
      valid    <= valid_n;
      data     <= data_n;
      ack      <= ack_n;
      cnt      <= cnt_n;
      err      <= err_n;
    end
  end

  always_comb begin
    state_n    = state;
    req_seen_n = req_seen;
    valid_n    = valid;
    data_n     = data;
    ack_n      = ack;
    cnt_n      = cnt;
    err_n      = err;
    unique case (state)
      IDLE: begin
        if (toggle_det && !valid) begin
          data_n     = bus.DATA;
          valid_n    = 1'b1;
          req_seen_n = req_s;
          state_n    = FULL;
        end
      end
      FULL: begin
        // Sender toggled again before ACK; req_seen is left
        // alone so the new level is picked up once IDLE.
        if (toggle_det) begin
          err_n = 1'b1;
        end
        if (valid && bus.OUT_READY) begin
          valid_n = 1'b0;
          ack_n   = ~ack;
          cnt_n   = cnt + CNT_WIDTH'(1);
          state_n = IDLE;
        end
      end
    endcase
  end

  assign bus.ACK       = ack;
  assign bus.OUT_VALID = valid;
  assign bus.OUT_DATA  = data;
  assign COUNT         = cnt;
  assign ERR           = err;

endmodule

// File: tb/tb_toggle_handshake_rx.sv
// Directed + random bench for toggle_handshake_rx.
// Reference model: expected word, transfer count, ack parity, err flag.
module tb_toggle_handshake_rx;

  localparam int W  = 8;
  localparam int SS = 2;
  localparam int CW = 2;
  localparam int LAT = SS + 1;

  logic          CLK;
  logic          RST;
  logic [CW-1:0] COUNT;
  logic          ERR;

  int total;
  int bad;

  // reference model state
  int   m_count;
  logic m_ack;
  logic m_err;
  logic req_lvl;

  toggle_handshake_rx_if #(.WIDTH(W)) bus ();

  toggle_handshake_rx #(
    .WIDTH       (W),
    .SYNC_STAGES (SS),
    .CNT_WIDTH   (CW)
  ) dut (
    .CLK   (CLK),
    .RST   (RST),
    .bus   (bus.slave),
    .COUNT (COUNT),
    .ERR   (ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic model_reset();
    m_count = 0;
    m_ack   = 1'b0;
    m_err   = 1'b0;
  endtask

  task automatic model_accept();
    m_count = (m_count + 1) % (1 << CW);
    m_ack   = ~m_ack;
  endtask

  // count edges until OUT_VALID rises, bounded
  task automatic wait_valid(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.OUT_VALID && n < 20);
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_ack"}, 32'(bus.ACK), 32'(m_ack));
    chk({tag, "_cnt"}, 32'(COUNT), 32'(m_count));
    chk({tag, "_err"}, 32'(ERR), 32'(m_err));
  endtask

  // full transfer: toggle, expect capture after LAT edges,
  // stall `hold` cycles, then accept
  task automatic xfer(input string tag,
                      input logic [W-1:0] word,
                      input int hold);
    int n;
    bus.DATA      = word;
    req_lvl       = ~req_lvl;
    bus.REQ       = req_lvl;
    bus.OUT_READY = (hold == 0);
    wait_valid(n);
    chk({tag, "_lat"}, 32'(n), 32'(LAT));
    chk({tag, "_dat"}, 32'(bus.OUT_DATA), 32'(word));
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({tag, "_hv"}, 32'(bus.OUT_VALID), 32'd1);
      chk({tag, "_hd"}, 32'(bus.OUT_DATA), 32'(word));
      chk({tag, "_ha"}, 32'(bus.ACK), 32'(m_ack));
    end
    bus.OUT_READY = 1'b1;
    tick();
    bus.OUT_READY = 1'b0;
    model_accept();
    chk({tag, "_v0"}, 32'(bus.OUT_VALID), 32'd0);
    check_state(tag);
  endtask

  initial begin
    int n;
    logic [W-1:0] w;
    total = 0;
    bad   = 0;
    req_lvl       = 1'b0;
    bus.REQ       = 1'b0;
    bus.DATA      = '0;
    bus.OUT_READY = 1'b0;
    model_reset();

    // reset state
    RST = 1'b0;
    repeat (3) tick();
    chk("rst_valid", 32'(bus.OUT_VALID), 32'd0);
    chk("rst_data", 32'(bus.OUT_DATA), 32'd0);
    check_state("rst");
    RST = 1'b1;
    repeat (2) tick();

    // first transfer, ready already high
    xfer("t1", 8'hA5, 0);

    // second transfer with 10-cycle stall
    xfer("t2", 8'h3C, 10);

    // violation: toggle again while FULL
    bus.DATA = 8'h3C;
    req_lvl  = ~req_lvl;
    bus.REQ  = req_lvl;
    wait_valid(n);
    chk("v_lat", 32'(n), 32'(LAT));
    bus.DATA = 8'h77;
    req_lvl  = ~req_lvl;
    bus.REQ  = req_lvl;
    repeat (LAT + 1) tick();
    m_err = 1'b1;
    chk("v_err", 32'(ERR), 32'd1);
    chk("v_hold", 32'(bus.OUT_DATA), 32'h3C);
    chk("v_valid", 32'(bus.OUT_VALID), 32'd1);
    bus.OUT_READY = 1'b1;
    tick();
    bus.OUT_READY = 1'b0;
    model_accept();
    check_state("v_acc");
    tick();
    chk("v_new_v", 32'(bus.OUT_VALID), 32'd1);
    chk("v_new_d", 32'(bus.OUT_DATA), 32'h77);
    bus.OUT_READY = 1'b1;
    tick();
    bus.OUT_READY = 1'b0;
    model_accept();
    check_state("v_acc2");

    // random transfers, count wraps mod 4
    for (int i = 0; i < 7; i++) begin
      w = W'($urandom);
      xfer("rnd", w, int'($urandom_range(0, 4)));
    end

    // async reset while FULL
    bus.DATA = 8'h5A;
    req_lvl  = ~req_lvl;
    bus.REQ  = req_lvl;
    wait_valid(n);
    chk("ar_full", 32'(bus.OUT_VALID), 32'd1);
    #3;
    RST = 1'b0;
    #1;
    model_reset();
    chk("ar_valid", 32'(bus.OUT_VALID), 32'd0);
    check_state("ar");

    // release with REQ=1: counts as one transfer
    req_lvl  = 1'b1;
    bus.REQ  = 1'b1;
    bus.DATA = 8'hC3;
    tick();
    #2;
    RST = 1'b1;
    bus.OUT_READY = 1'b0;
    wait_valid(n);
    chk("rr_lat", 32'(n), 32'(LAT));
    chk("rr_dat", 32'(bus.OUT_DATA), 32'hC3);
    bus.OUT_READY = 1'b1;
    tick();
    bus.OUT_READY = 1'b0;
    model_accept();
    check_state("rr");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
